axis_frame_arbiter: RTL
=======================

// Module: axis_frame_arbiter
// PURPOSE
//   Shares one perceptron datapath (AXIS frame in, AXIS result frame out) among
//   NUM_SRC AXI-stream input sources. Grants one source per frame, round-robin.
//   Forwards FRAME_LEN beats, then returns RESULT_LEN result beats tagged with the
//   source ID. Exactly one frame is in flight at a time.
// PARAMETERS
//   NUM_SRC      4   number of requesting input streams (>=2)
//   DATA_WIDTH   32  input beat width
//   FRAME_LEN    8   beats per input frame (= datapath INP_DEPTH)
//   RESULT_LEN   2   beats per result frame (= datapath OUT_DEPTH)
//   RESULT_WIDTH 35  result beat width (DATA_WIDTH+clog2(FRAME_LEN))
//   ID_W  (local)    max(1,clog2(NUM_SRC))
// PORTS
//   axi_clk       in  1                    clock
//   axi_reset_n   in  1                    sync reset, active low
//   s_axis_valid  in  NUM_SRC              per-source valid
//   s_axis_data   in  NUM_SRC*DATA_WIDTH   per-source data, source k at [k*DATA_WIDTH+:DATA_WIDTH]
//   s_axis_ready  out NUM_SRC              per-source ready
//   m_axis_valid  out 1                    to datapath input
//   m_axis_data   out DATA_WIDTH           to datapath input
//   m_axis_ready  in  1                    from datapath input
//   r_axis_valid  in  1                    datapath result valid
//   r_axis_data   in  RESULT_WIDTH         datapath result data
//   r_axis_ready  out 1                    datapath result ready
//   o_axis_valid  out 1                    tagged result valid
//   o_axis_data   out RESULT_WIDTH         tagged result data
//   o_axis_id     out ID_W                 source index owning the result
//   o_axis_last   out 1                    final beat of result frame
//   o_axis_ready  in  1                    result consumer ready
// BEHAVIOUR
//   States: IDLE, FWD, RES. Regs: state, grant[ID_W], rr_ptr[ID_W], beat_cnt, res_cnt.
//   Reset (axi_reset_n=0 at edge): state=IDLE, grant=0, rr_ptr=0, counters=0.
//     All outputs 0 while in IDLE with no pending work. Reset mid-frame abandons the frame;
//     datapath shares the same reset.
//   IDLE: all s_axis_ready=0, m_axis_valid=0, r_axis_ready=0, o_axis_valid=0.
//     If any s_axis_valid: grant <= first k with valid set, searching rr_ptr, rr_ptr+1, ... mod NUM_SRC;
//     state <= FWD. Arbitration latency: 1 cycle.
//   FWD: combinational pass-through, zero latency:
//     m_axis_valid=s_axis_valid[grant], m_axis_data=source grant data,
//     s_axis_ready[grant]=m_axis_ready, other readies 0. Grant is locked for the whole frame.
//     Each handshake increments beat_cnt. On the FRAME_LEN-th handshake: beat_cnt<=0, state<=RES.
//     Gaps (valid low) are allowed; the grant holds.
//   RES: o_axis_valid=r_axis_valid, o_axis_data=r_axis_data, o_axis_id=grant,
//     r_axis_ready=o_axis_ready, o_axis_last=(res_cnt==RESULT_LEN-1).
//     Each o-handshake increments res_cnt. On the RESULT_LEN-th handshake: res_cnt<=0,
//     rr_ptr<=(grant+1) mod NUM_SRC, state<=IDLE.
//   r_axis_ready=0 outside RES; results presented early stall.
//   s_axis_ready all 0 outside FWD; source valid/data must stay stable while waiting (AXIS rule).
//   Simultaneous requests: resolved only by rr_ptr order. A source that drops valid in IDLE
//     before grant is not granted. Valid changes after grant do not change grant.
//   Counter widths: clog2(FRAME_LEN+1), clog2(RESULT_LEN+1); no wrap beyond terminal count.
// TESTING
//   1 Reset, then src2 only sends 8 beats 1..8 -> grant=2 after 1 cycle; m_axis sees 1..8; src0/1/3 ready=0.
//   2 All 4 sources valid continuously, 4 frames -> grant order 0,1,2,3; next frame grants 0.
//   3 After grant=1 frame, src0 and src3 valid -> src3 granted (rr_ptr=2 scan order 2,3,0).
//   4 m_axis_ready toggles 1/0 every cycle -> exactly 8 handshakes, no beat dropped or duplicated.
//   5 Results 0x11,0x22 with o_axis_ready low 3 cycles -> r_axis_ready held low; then id=grant, last on 0x22.
//   6 Reset asserted after 5 beats of a frame -> next cycle IDLE, all readies/valids 0, rr_ptr=0.

Source files
------------

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter
//   Shares a single perceptron datapath among NUM_SRC AXI-stream sources.
//   One source is granted per frame in round-robin order; FRAME_LEN input
//   beats are passed through to the datapath, then RESULT_LEN result beats
//   are returned tagged with the owning source index. One frame in flight.
//
// Ports
//   axi_clk, axi_reset_n          clock, synchronous active-low reset
//   s_axis_valid/data/ready       per-source input streams (source k at slice k)
//   m_axis_valid/data/ready       granted stream towards the datapath input
//   r_axis_valid/data/ready       result stream from the datapath
//   o_axis_valid/data/id/last/ready  tagged result stream to the consumer
module axis_frame_arbiter #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FRAME_LEN    = 8,
    parameter int unsigned RESULT_LEN   = 2,
    parameter int unsigned RESULT_WIDTH = 35,
    localparam int unsigned ID_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          axi_clk,
    input  logic                          axi_reset_n,
    input  logic [NUM_SRC-1:0]            s_axis_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_data,
    output logic [NUM_SRC-1:0]            s_axis_ready,
    output logic                          m_axis_valid,
    output logic [DATA_WIDTH-1:0]         m_axis_data,
    input  logic                          m_axis_ready,
    input  logic                          r_axis_valid,
    input  logic [RESULT_WIDTH-1:0]       r_axis_data,
    output logic                          r_axis_ready,
    output logic                          o_axis_valid,
    output logic [RESULT_WIDTH-1:0]       o_axis_data,
    output logic [ID_W-1:0]               o_axis_id,
    output logic                          o_axis_last,
    input  logic                          o_axis_ready
);

    localparam int unsigned BW = $clog2(FRAME_LEN + 1);
    localparam int unsigned RW = $clog2(RESULT_LEN + 1);

    typedef enum logic [1:0] {StIdle, StFwd, StRes} state_e;

    state_e          state;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] rr_ptr;
    logic [BW-1:0]   beat_cnt;
    logic [RW-1:0]   res_cnt;

    logic [ID_W-1:0] pick;
    logic            pick_found;
    logic [ID_W-1:0] cand;
    int unsigned     idx;
    logic            m_hs;
    logic            o_hs;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        idx        = 0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx  = (32'(rr_ptr) + i) % NUM_SRC;
            cand = ID_W'(idx);
            if (!pick_found && s_axis_valid[cand]) begin
                pick       = cand;
                pick_found = 1'b1;
            end
        end
    end

    // Zero-latency pass-through in FWD and RES; everything quiet otherwise.
    always_comb begin
        s_axis_ready = '0;
        m_axis_valid = 1'b0;
        m_axis_data  = '0;
        r_axis_ready = 1'b0;
        o_axis_valid = 1'b0;
        o_axis_data  = '0;
        o_axis_id    = '0;
        o_axis_last  = 1'b0;
        unique case (state)
            StFwd: begin
                m_axis_valid        = s_axis_valid[grant];
                m_axis_data         = s_axis_data[grant*DATA_WIDTH +: DATA_WIDTH];
                s_axis_ready[grant] = m_axis_ready;
            end
            StRes: begin
                o_axis_valid = r_axis_valid;
                o_axis_data  = r_axis_data;
                o_axis_id    = grant;
                o_axis_last  = (res_cnt == RW'(RESULT_LEN - 1));
                r_axis_ready = o_axis_ready;
            end
            default: ;
        endcase
    end

    assign m_hs = (state == StFwd) && m_axis_valid && m_axis_ready;
    assign o_hs = (state == StRes) && r_axis_valid && o_axis_ready;

    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            state    <= StIdle;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            res_cnt  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (pick_found) begin
                        grant <= pick;
                        state <= StFwd;
                    end
                end
                StFwd: begin
                    if (m_hs) begin
                        if (beat_cnt == BW'(FRAME_LEN - 1)) begin
                            beat_cnt <= '0;
                            state    <= StRes;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                StRes: begin
                    if (o_hs) begin
                        if (res_cnt == RW'(RESULT_LEN - 1)) begin
                            res_cnt <= '0;
                            rr_ptr  <= (grant == ID_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
                            state   <= StIdle;
                        end else begin
                            res_cnt <= res_cnt + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
